// File: rtl/bcd_excess_converter.sv
// Multi-digit BCD <-> excess-BIAS converter. One digit per clock, LSD first,
// with a start/busy/done handshake and a sticky invalid-digit flag.
module bcd_excess_converter #(
  parameter int DIGITS = 4,
  parameter int BIAS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [4*DIGITS-1:0]  operand;
  logic                 mode_r;

  logic [3:0] digit;
  logic [3:0] conv_digit;
  logic       conv_bad;
  logic [4:0] diff;

  always_comb begin
    digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) digit = operand[i*4 +: 4];
    end
  end

  // Reverse range check via a 5-bit subtract: a borrow means e < BIAS.
  always_comb begin
    diff       = {1'b0, digit} - 5'(BIAS);
    conv_digit = 4'hF;
    conv_bad   = 1'b1;
    if (!mode_r) begin
      if (digit <= 4'd9) begin
        conv_digit = digit + 4'(BIAS);
        conv_bad   = 1'b0;
      end
    end else begin
      if (!diff[4] && (diff[3:0] <= 4'd9)) begin
        conv_digit = diff[3:0];
        conv_bad   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      operand <= '0;
      mode_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      dout    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= CONV;
            operand <= din;
            mode_r  <= mode;
            idx     <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) dout[i*4 +: 4] <= conv_digit;
          end
          if (conv_bad) err <= 1'b1;
          if (idx == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_excess_converter.sv
// Directed bench for bcd_excess_converter: DIGITS=4/BIAS=3 main instance and
// a DIGITS=1/BIAS=0 corner instance, expected values computed by hand.
module tb_bcd_excess_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode;
  logic [15:0] din;
  logic        busy, done, err;
  logic [15:0] dout;

  logic        start1, mode1;
  logic [3:0]  din1;
  logic        busy1, done1, err1;
  logic [3:0]  dout1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_excess_converter #(.DIGITS(4), .BIAS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
    .busy(busy), .done(done), .dout(dout), .err(err)
  );

  bcd_excess_converter #(.DIGITS(1), .BIAS(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .din(din1),
    .busy(busy1), .done(done1), .dout(dout1), .err(err1)
  );

  // Pulses start for one edge, then waits (bounded) for done. lat counts
  // negedges from the one right after the start edge (=1) to the done cycle.
  task automatic run(input logic [15:0] d, input logic m, output int lat, output int busy_n);
    @(negedge clk); din = d; mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1; busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(negedge clk); lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if ({busy, done, err, dout} !== 19'h0) begin errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b dout=%h want all 0", busy, done, err, dout); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dout !== 16'h0) begin errors++;
      $display("FAIL reset_idle: got busy=%b done=%b dout=%h want 0 0 0000", busy, done, dout); end
  endtask

  task automatic test_forward();
    int lat, bn;
    run(16'h1234, 1'b0, lat, bn);
    checks++; if (done !== 1'b1 || lat != 5) begin errors++;
      $display("FAIL fwd_latency: got done=%b lat=%0d want done=1 lat=5", done, lat); end
    checks++; if (bn != 4 || busy !== 1'b0) begin errors++;
      $display("FAIL fwd_busy: got busy_cycles=%0d busy_in_done=%b want 4 0", bn, busy); end
    checks++; if (dout !== 16'h4567 || err !== 1'b0) begin errors++;
      $display("FAIL fwd_result: got dout=%h err=%b want 4567 0", dout, err); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || dout !== 16'h4567) begin errors++;
      $display("FAIL fwd_done_pulse: got done=%b dout=%h want 0 4567", done, dout); end
  endtask

  task automatic test_reverse();
    int lat, bn;
    run(16'h4567, 1'b1, lat, bn);
    checks++; if (done !== 1'b1 || dout !== 16'h1234 || err !== 1'b0) begin errors++;
      $display("FAIL rev_result: got done=%b dout=%h err=%b want 1 1234 0", done, dout, err); end
    run(16'h3C3C, 1'b1, lat, bn);
    checks++; if (done !== 1'b1 || dout !== 16'h0909 || err !== 1'b0) begin errors++;
      $display("FAIL rev_boundary: got done=%b dout=%h err=%b want 1 0909 0", done, dout, err); end
  endtask

  task automatic test_invalid();
    int lat, bn;
    run(16'h12A4, 1'b0, lat, bn);
    checks++; if (done !== 1'b1 || dout !== 16'h45F7 || err !== 1'b1) begin errors++;
      $display("FAIL inv_fwd: got done=%b dout=%h err=%b want 1 45F7 1", done, dout, err); end
    // digit 2 (=2) and digit 3 (=0) are both below BIAS in reverse mode
    run(16'h0234, 1'b1, lat, bn);
    checks++; if (done !== 1'b1 || dout !== 16'hFF01 || err !== 1'b1) begin errors++;
      $display("FAIL inv_rev: got done=%b dout=%h err=%b want 1 FF01 1", done, dout, err); end
    run(16'h0000, 1'b0, lat, bn);
    checks++; if (done !== 1'b1 || dout !== 16'h3333 || err !== 1'b0) begin errors++;
      $display("FAIL inv_clear: got done=%b dout=%h err=%b want 1 3333 0", done, dout, err); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk); din = 16'h1234; mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; din = 16'h9999; mode = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (done !== 1'b1 || lat != 5 || dout !== 16'h4567 || err !== 1'b0) begin errors++;
      $display("FAIL mid_start: got done=%b lat=%0d dout=%h err=%b want 1 5 4567 0", done, lat, dout, err); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL mid_start_queued: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, gap;
    run(16'h1234, 1'b0, lat, bn);
    checks++; if (done !== 1'b1 || dout !== 16'h4567) begin errors++;
      $display("FAIL b2b_first: got done=%b dout=%h want 1 4567", done, dout); end
    din = 16'h4567; mode = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; din = 16'h0000; mode = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL b2b_no_idle: got busy=%b done=%b want 1 0", busy, done); end
    gap = 1;
    while (!done && gap < 20) begin @(negedge clk); gap++; end
    checks++; if (done !== 1'b1 || gap != 5 || dout !== 16'h1234 || err !== 1'b0) begin errors++;
      $display("FAIL b2b_second: got done=%b spacing=%0d dout=%h err=%b want 1 5 1234 0", done, gap, dout, err); end
  endtask

  task automatic test_reset_mid();
    int lat, bn, seen;
    @(negedge clk); din = 16'h1234; mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || dout[7:0] !== 8'h67) begin errors++;
      $display("FAIL rstmid_partial: got busy=%b dout_lo=%h want 1 67", busy, dout[7:0]); end
    rst = 1'b1; #1;
    checks++; if ({busy, done, err, dout} !== 19'h0) begin errors++;
      $display("FAIL rstmid_zero: got busy=%b done=%b err=%b dout=%h want all 0", busy, done, err, dout); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (7) begin @(negedge clk); if (done || busy) seen++; end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL rstmid_no_done: got active_cycles=%0d want 0", seen); end
    run(16'h4567, 1'b1, lat, bn);
    checks++; if (done !== 1'b1 || lat != 5 || dout !== 16'h1234 || err !== 1'b0) begin errors++;
      $display("FAIL rstmid_next: got done=%b lat=%0d dout=%h err=%b want 1 5 1234 0", done, lat, dout, err); end
  endtask

  task automatic test_single_digit();
    logic [3:0] vin   [3] = '{4'h7, 4'h9, 4'hA};
    logic       vmode [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] vexp  [3] = '{4'h7, 4'h9, 4'hF};
    logic       verr  [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); din1 = vin[i]; mode1 = vmode[i]; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++;
        $display("FAIL d1_busy[%0d]: got busy=%b done=%b want 1 0", i, busy1, done1); end
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || dout1 !== vexp[i] || err1 !== verr[i]) begin errors++;
        $display("FAIL d1_result[%0d]: got done=%b dout=%h err=%b want 1 %h %b", i, done1, dout1, err1, vexp[i], verr[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; din = 16'h0;
    start1 = 1'b0; mode1 = 1'b0; din1 = 4'h0;
    #12;
    test_reset();
    test_forward();
    test_reverse();
    test_invalid();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_single_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
